pc_target_lut: RTL and testbench

//  Programmable branch-target table for the fetch stage. Branch instructions carry a short

---
 rtl/pc_lut_pkg.sv | 26 ++
 rtl/pc_target_adder.sv | 21 ++
 rtl/pc_target_lut.sv | 119 +++++++++++
 tb/tb_pc_target_lut.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pc_lut_pkg.sv
// ============================================================================
// Module  : pc_lut_pkg
// Brief   : Shared types and default widths for the branch-target lookup table.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_lut_pkg;

    localparam int LUT_D  = 10;
    localparam int LUT_AW = 4;

    typedef struct packed {
        logic              valid;
        logic              rel;
        logic [LUT_D-1:0]  data;
    } pc_lut_entry_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } pc_lut_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_target_adder.sv
// ============================================================================
// Module  : pc_target_adder
// Brief   : D-bit wrap-around adder used for relative targets and fall-through.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_target_adder #(
    parameter int D = 10
) (
    input  logic [D-1:0] i_a,
    input  logic [D-1:0] i_b,
    output logic [D-1:0] o_sum
);

    // Carry out is discarded: target arithmetic wraps silently modulo 2**D.
    assign o_sum = i_a + i_b;

endmodule

`default_nettype wire

// File: rtl/pc_target_lut.sv
// ============================================================================
// Module  : pc_target_lut
// Brief   : Run-time programmable branch-target table with one-cycle lookup.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_target_lut
    import pc_lut_pkg::*;
#(
    parameter int D  = LUT_D,
    parameter int AW = LUT_AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [D-1:0]  wr_data,
    input  logic          wr_rel,
    input  logic          lk_valid,
    input  logic [AW-1:0] lk_addr,
    input  logic [D-1:0]  lk_pc,
    output logic          init_busy,
    output logic          tgt_valid,
    output logic          tgt_miss,
    output logic [D-1:0]  target
);

    localparam int DEPTH = 2**AW;

    pc_lut_state_t  r_state;
    logic [AW-1:0]  r_sweep;
    pc_lut_entry_t  r_tbl [DEPTH];
    logic           r_init_busy;
    logic           r_tgt_valid;
    logic           r_tgt_miss;
    logic [D-1:0]   r_target;

    logic           w_run;
    logic           w_wr;
    logic           w_lk;
    pc_lut_entry_t  w_new_entry;
    pc_lut_entry_t  w_entry;
    logic [D-1:0]   w_add_b;
    logic [D-1:0]   w_sum;
    logic [D-1:0]   w_result;

    assign w_run = (r_state == RUN);
    assign w_wr  = w_run && wr_en;
    assign w_lk  = w_run && lk_valid;

    always_comb begin
        w_new_entry       = '0;
        w_new_entry.valid = 1'b1;
        w_new_entry.rel   = wr_rel;
        w_new_entry.data  = wr_data;
    end

    // Write-first bypass: a lookup racing a write to the same index sees the new entry.
    always_comb begin
        w_entry = r_tbl[lk_addr];
        if (w_wr && (wr_addr == lk_addr)) begin
            w_entry = w_new_entry;
        end
    end

    // One adder serves both paths: relative hit adds the offset, miss adds one.
    assign w_add_b  = w_entry.valid ? w_entry.data : D'(1);
    assign w_result = (w_entry.valid && !w_entry.rel) ? w_entry.data : w_sum;

    pc_target_adder #(
        .D (D)
    ) u_adder (
        .i_a   (lk_pc),
        .i_b   (w_add_b),
        .o_sum (w_sum)
    );

    // Storage has no reset; the INIT sweep is the only thing that clears it.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_tbl[r_sweep] <= '0;
        end else if (wr_en) begin
            r_tbl[wr_addr] <= w_new_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= INIT;
            r_sweep     <= '0;
            r_init_busy <= 1'b1;
            r_tgt_valid <= 1'b0;
            r_tgt_miss  <= 1'b0;
            r_target    <= '0;
        end else begin
            r_tgt_valid <= w_lk;
            if (w_lk) begin
                r_tgt_miss <= !w_entry.valid;
                r_target   <= w_result;
            end
            if (r_state == INIT) begin
                r_sweep <= r_sweep + AW'(1);
                if (r_sweep == AW'(DEPTH-1)) begin
                    r_state     <= RUN;
                    r_init_busy <= 1'b0;
                end
            end
        end
    end

    assign init_busy = r_init_busy;
    assign tgt_valid = r_tgt_valid;
    assign tgt_miss  = r_tgt_miss;
    assign target    = r_target;

endmodule

`default_nettype wire

// File: tb/tb_pc_target_lut.sv
// ============================================================================
// Module  : tb_pc_target_lut
// Brief   : Directed self-checking bench for pc_target_lut (D=10, AW=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_target_lut;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [9:0] wr_data;
    logic       wr_rel;
    logic       lk_valid;
    logic [3:0] lk_addr;
    logic [9:0] lk_pc;
    logic       init_busy;
    logic       tgt_valid;
    logic       tgt_miss;
    logic [9:0] target;

    int n_cmp = 0;
    int n_err = 0;

    pc_target_lut #(
        .D  (10),
        .AW (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_rel    (wr_rel),
        .lk_valid  (lk_valid),
        .lk_addr   (lk_addr),
        .lk_pc     (lk_pc),
        .init_busy (init_busy),
        .tgt_valid (tgt_valid),
        .tgt_miss  (tgt_miss),
        .target    (target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_result(input string tag, input logic v, input logic m, input logic [9:0] t);
        check({tag, ".valid"}, {31'd0, tgt_valid}, {31'd0, v});
        check({tag, ".miss"},  {31'd0, tgt_miss},  {31'd0, m});
        check({tag, ".target"}, {22'd0, target},   {22'd0, t});
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 4'd0;
        wr_data  = 10'd0;
        wr_rel   = 1'b0;
        lk_valid = 1'b0;
        lk_addr  = 4'd0;
        lk_pc    = 10'd0;
        step();
        step();
        check("reset.busy", {31'd0, init_busy}, 32'd1);
        check_result("reset", 1'b0, 1'b0, 10'd0);

        // Traffic during INIT must be dropped; idx12 is written every sweep cycle.
        wr_en    = 1'b1;
        wr_addr  = 4'd12;
        wr_data  = 10'd55;
        lk_valid = 1'b1;
        lk_addr  = 4'd12;
        reset_n  = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("init.busy[%0d]", k), {31'd0, init_busy}, (k < 16) ? 32'd1 : 32'd0);
            check($sformatf("init.valid[%0d]", k), {31'd0, tgt_valid}, 32'd0);
        end
        wr_en    = 1'b0;
        lk_valid = 1'b0;
        step();

        // Absolute hit.
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 10'd11; wr_rel = 1'b0;
        step();
        wr_en = 1'b0;
        lk_valid = 1'b1; lk_addr = 4'd1; lk_pc = 10'd500;
        step();
        check_result("abs1", 1'b1, 1'b0, 10'd11);
        lk_valid = 1'b0;

        // Relative negative offset, then positive offset with wrap.
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 10'h3FB; wr_rel = 1'b1;
        step();
        wr_en = 1'b0;
        lk_valid = 1'b1; lk_addr = 4'd9; lk_pc = 10'd4;
        step();
        check_result("rel9", 1'b1, 1'b0, 10'h3FF);
        lk_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd10; wr_data = 10'd20; wr_rel = 1'b1;
        step();
        wr_en = 1'b0;
        lk_valid = 1'b1; lk_addr = 4'd10; lk_pc = 10'd1020;
        step();
        check_result("rel10wrap", 1'b1, 1'b0, 10'd16);

        // Misses: fall-through and fall-through wrap.
        lk_addr = 4'd12; lk_pc = 10'd7;
        step();
        check_result("miss12", 1'b1, 1'b1, 10'd8);
        lk_pc = 10'd1023;
        step();
        check_result("miss12wrap", 1'b1, 1'b1, 10'd0);

        // No request: valid drops, miss and target hold.
        lk_valid = 1'b0; lk_pc = 10'd300;
        step();
        check_result("idle", 1'b0, 1'b1, 10'd0);

        // Same-cycle write and lookup to one index: bypass.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 10'd121; wr_rel = 1'b0;
        lk_valid = 1'b1; lk_addr = 4'd3; lk_pc = 10'd50;
        step();
        check_result("bypass3", 1'b1, 1'b0, 10'd121);

        // Write to another index alongside lookup idx1: no interaction.
        wr_addr = 4'd2; wr_data = 10'd77;
        lk_addr = 4'd1; lk_pc = 10'd0;
        step();
        wr_en = 1'b0;
        check_result("b2b1", 1'b1, 1'b0, 10'd11);
        lk_addr = 4'd9; lk_pc = 10'd4;
        step();
        check_result("b2b9", 1'b1, 1'b0, 10'h3FF);
        lk_addr = 4'd2; lk_pc = 10'd900;
        step();
        check_result("idx2", 1'b1, 1'b0, 10'd77);

        // Overwrite idx1 with a relative entry.
        lk_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 10'd200; wr_rel = 1'b1;
        step();
        wr_en = 1'b0;
        lk_valid = 1'b1; lk_addr = 4'd1; lk_pc = 10'd900;
        step();
        check_result("over1", 1'b1, 1'b0, 10'd76);

        // Asynchronous reset with a lookup result pending.
        #2;
        reset_n = 1'b0;
        #1;
        check("areset.busy", {31'd0, init_busy}, 32'd1);
        check_result("areset", 1'b0, 1'b0, 10'd0);
        @(negedge clk);
        lk_valid = 1'b0;
        reset_n  = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
        end
        check("reinit.busy", {31'd0, init_busy}, 32'd0);
        lk_valid = 1'b1; lk_addr = 4'd1; lk_pc = 10'd100;
        step();
        check_result("postreset1", 1'b1, 1'b1, 10'd101);
        lk_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
